// File: rtl/cam_pkg.sv
// Shared types and defaults for the synthetic camera stream source.
// Frame geometry defaults, RGB444 pixel struct and timing FSM states.
package cam_pkg;

   localparam int H_ACTIVE_D  = 320;
   localparam int V_ACTIVE_D  = 240;
   localparam int H_BLANK_D   = 16;
   localparam int VSYNC_CYC_D = 8;
   localparam int VBP_CYC_D   = 16;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam rgb444_t ORANGE_RGB = 12'hF80;
   localparam rgb444_t BG_RGB     = 12'h222;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBP,
      ST_ACTIVE,
      ST_HBLANK,
      ST_DONE
   } cam_state_e;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cam_timing_gen.sv
// Frame timing FSM with column/row counters for the camera emulator.
// Outputs are decoded from the current state; the top registers them.
module cam_timing_gen
   import cam_pkg::*;
#(
   parameter int H_ACTIVE  = H_ACTIVE_D,
   parameter int V_ACTIVE  = V_ACTIVE_D,
   parameter int H_BLANK   = H_BLANK_D,
   parameter int VSYNC_CYC = VSYNC_CYC_D,
   parameter int VBP_CYC   = VBP_CYC_D
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   output logic                        vsync,
   output logic                        href,
   output logic                        done,
   output logic                        start,
   output logic [$clog2(H_ACTIVE)-1:0] col,
   output logic [$clog2(V_ACTIVE)-1:0] row
);

   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = $clog2(V_ACTIVE);
   localparam int CW = $clog2(max3(VSYNC_CYC, VBP_CYC, H_BLANK) + 1);

   cam_state_e    state;
   cam_state_e    next;
   logic [CW-1:0] cnt;
   logic [XW-1:0] col_cnt;
   logic [YW-1:0] row_cnt;
   logic          cnt_run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         ST_IDLE:   if (enable) next = ST_VSYNC;
         ST_VSYNC:  if (cnt == CW'(VSYNC_CYC - 1)) next = ST_VBP;
         ST_VBP:    if (cnt == CW'(VBP_CYC - 1)) next = ST_ACTIVE;
         ST_ACTIVE: if (col_cnt == XW'(H_ACTIVE - 1)) next = ST_HBLANK;
         ST_HBLANK:
            if (cnt == CW'(H_BLANK - 1))
               next = (row_cnt == YW'(V_ACTIVE - 1)) ? ST_DONE : ST_ACTIVE;
         ST_DONE:   next = enable ? ST_VSYNC : ST_IDLE;
         default:   next = ST_IDLE;
      endcase
   end

   // the shared cycle counter only runs inside the fixed-length states
   assign cnt_run = (state == ST_VSYNC) || (state == ST_VBP) ||
                    (state == ST_HBLANK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         col_cnt <= '0;
         row_cnt <= '0;
      end else begin
         cnt <= (cnt_run && next == state) ? cnt + CW'(1) : '0;
         if (state == ST_ACTIVE && next == ST_ACTIVE)
            col_cnt <= col_cnt + XW'(1);
         else
            col_cnt <= '0;
         if (state == ST_HBLANK && next == ST_ACTIVE)
            row_cnt <= row_cnt + YW'(1);
         else if (state == ST_HBLANK && next == ST_DONE)
            row_cnt <= '0;
      end
   end

   assign vsync = (state == ST_VSYNC);
   assign href  = (state == ST_ACTIVE);
   assign done  = (state == ST_DONE);
   assign start = (next == ST_VSYNC) && (state != ST_VSYNC);
   assign col   = col_cnt;
   assign row   = row_cnt;

endmodule

// File: rtl/camera_stream_emulator.sv
// Synthetic OV-style camera source painting an orange box on a grey field.
// Box bounds are captured at frame start; all outputs are registered.
module camera_stream_emulator
   import cam_pkg::*;
#(
   parameter int H_ACTIVE  = H_ACTIVE_D,
   parameter int V_ACTIVE  = V_ACTIVE_D,
   parameter int H_BLANK   = H_BLANK_D,
   parameter int VSYNC_CYC = VSYNC_CYC_D,
   parameter int VBP_CYC   = VBP_CYC_D
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [8:0] box_x0,
   input  logic [8:0] box_x1,
   input  logic [7:0] box_y0,
   input  logic [7:0] box_y1,
   output logic       VSYNC,
   output logic       HREF,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       is_orange,
   output logic [8:0] col,
   output logic [7:0] row,
   output logic       frame_done
);

   logic                        t_vsync;
   logic                        t_href;
   logic                        t_done;
   logic                        t_start;
   logic [$clog2(H_ACTIVE)-1:0] t_col;
   logic [$clog2(V_ACTIVE)-1:0] t_row;
   logic [8:0]                  bx0, bx1;
   logic [7:0]                  by0, by1;
   logic [8:0]                  col_x;
   logic [7:0]                  row_y;
   logic                        in_box;
   rgb444_t                     pix;

   cam_timing_gen #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .H_BLANK   (H_BLANK),
      .VSYNC_CYC (VSYNC_CYC),
      .VBP_CYC   (VBP_CYC)
   ) u_timing (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .vsync  (t_vsync),
      .href   (t_href),
      .done   (t_done),
      .start  (t_start),
      .col    (t_col),
      .row    (t_row)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bx0 <= '0;
         bx1 <= '0;
         by0 <= '0;
         by1 <= '0;
      end else if (t_start) begin
         bx0 <= box_x0;
         bx1 <= box_x1;
         by0 <= box_y0;
         by1 <= box_y1;
      end
   end

   assign col_x  = 9'(t_col);
   assign row_y  = 8'(t_row);
   // inverted bounds fall out as an empty box with no special case
   assign in_box = t_href && (col_x >= bx0) && (col_x <= bx1) &&
                   (row_y >= by0) && (row_y <= by1);
   assign pix    = in_box ? ORANGE_RGB : BG_RGB;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         VSYNC      <= 1'b0;
         HREF       <= 1'b0;
         frame_done <= 1'b0;
         is_orange  <= 1'b0;
         col        <= '0;
         row        <= '0;
         red        <= '0;
         green      <= '0;
         blue       <= '0;
      end else begin
         VSYNC      <= t_vsync;
         HREF       <= t_href;
         frame_done <= t_done;
         is_orange  <= in_box;
         col        <= t_href ? col_x : '0;
         row        <= row_y;
         red        <= t_href ? pix.r : '0;
         green      <= t_href ? pix.g : '0;
         blue       <= t_href ? pix.b : '0;
      end
   end

endmodule

// File: tb/tb_camera_stream_emulator.sv
// Random-box bench for camera_stream_emulator with a frame-position model.
// Small geometry keeps many frames inside a short run.
module tb_camera_stream_emulator;

   localparam int HA = 40;
   localparam int VA = 24;
   localparam int HB = 4;
   localparam int VS = 3;
   localparam int VB = 4;
   localparam int LN = HA + HB;
   localparam int P  = VS + VB + VA * LN + 1;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [8:0] box_x0, box_x1;
   logic [7:0] box_y0, box_y1;
   logic       VSYNC, HREF, is_orange, frame_done;
   logic [3:0] red, green, blue;
   logic [8:0] col;
   logic [7:0] row;

   int vectors = 0;
   int errors  = 0;

   camera_stream_emulator #(
      .H_ACTIVE  (HA),
      .V_ACTIVE  (VA),
      .H_BLANK   (HB),
      .VSYNC_CYC (VS),
      .VBP_CYC   (VB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .box_x0     (box_x0),
      .box_x1     (box_x1),
      .box_y0     (box_y0),
      .box_y1     (box_y1),
      .VSYNC      (VSYNC),
      .HREF       (HREF),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .is_orange  (is_orange),
      .col        (col),
      .row        (row),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int box_area(input int x0, input int x1,
                                   input int y0, input int y1);
      int hx, hy, nx, ny;
      hx = (x1 < HA - 1) ? x1 : HA - 1;
      hy = (y1 < VA - 1) ? y1 : VA - 1;
      nx = (hx >= x0) ? hx - x0 + 1 : 0;
      ny = (hy >= y0) ? hy - y0 + 1 : 0;
      return nx * ny;
   endfunction

   // model: position within a frame, or idle
   bit m_idle = 1'b1;
   int m_pos  = 0;
   int mx0, mx1, my0, my1;
   int e_vs, e_href, e_done, e_org, e_col, e_row, e_rgb;

   always @(posedge clk) begin
      int q, c;
      e_vs = 0; e_href = 0; e_done = 0; e_org = 0;
      e_col = 0; e_row = 0; e_rgb = 0;
      if (!rst_n) begin
         m_idle = 1'b1;
      end else begin
         if (!m_idle) begin
            if (m_pos < VS) e_vs = 1;
            else if (m_pos == P - 1) e_done = 1;
            else if (m_pos >= VS + VB) begin
               q = m_pos - VS - VB;
               e_row = q / LN;
               c = q % LN;
               if (c < HA) begin
                  e_href = 1;
                  e_col = c;
                  e_org = (c >= mx0 && c <= mx1 &&
                           e_row >= my0 && e_row <= my1) ? 1 : 0;
                  e_rgb = e_org ? 12'hF80 : 12'h222;
               end
            end
         end
         if (m_idle || m_pos == P - 1) begin
            if (enable) begin
               m_idle = 1'b0;
               m_pos = 0;
               mx0 = box_x0; mx1 = box_x1;
               my0 = box_y0; my1 = box_y1;
            end else begin
               m_idle = 1'b1;
            end
         end else begin
            m_pos++;
         end
      end
      #1;
      chk("VSYNC", VSYNC, e_vs);
      chk("HREF", HREF, e_href);
      chk("frame_done", frame_done, e_done);
      chk("is_orange", is_orange, e_org);
      chk("col", col, e_col);
      chk("row", row, e_row);
      chk("rgb", {red, green, blue}, e_rgb);
   end

   // drives the next box mid-frame; returns counts up to frame_done
   task automatic run_frame(input int nx0, input int nx1, input int ny0,
                            input int ny1, input bit en_after,
                            output int org, output int hr, output int n);
      org = 0; hr = 0; n = 0;
      for (int i = 0; i < 2 * P; i++) begin
         @(posedge clk); #2;
         n++;
         if (HREF) hr++;
         if (is_orange) org++;
         if (i == P / 2) begin
            box_x0 = 9'(nx0); box_x1 = 9'(nx1);
            box_y0 = 8'(ny0); box_y1 = 8'(ny1);
            enable = en_after;
         end
         if (frame_done) break;
      end
   endtask

   initial begin
      int org, hr, n, lat, nxt, cnt;
      int rx0, rx1, ry0, ry1;
      rst_n = 1'b0;
      enable = 1'b1;
      box_x0 = 9'd10; box_x1 = 9'd19;
      box_y0 = 8'd5;  box_y1 = 8'd14;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_href", HREF, 0);
      chk("rst_vsync", VSYNC, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #2 chk("vsync_edge1", VSYNC, 0);
      @(posedge clk); #2 chk("vsync_edge2", VSYNC, 1);

      run_frame(5, 14, 0, 23, 1'b1, org, hr, n);
      chk("f1_orange", org, 100);
      chk("f1_href", hr, 960);
      chk("f1_len", n, 1063);
      @(posedge clk); #2 chk("f1_next_vsync", VSYNC, 1);

      run_frame(30, 10, 0, 23, 1'b1, org, hr, n);
      chk("f2_orange", org, 240);
      chk("f2_len", n, P - 1);
      @(posedge clk); #2 chk("f2_next_vsync", VSYNC, 1);

      lat = 0;
      for (int k = 0; k < 3; k++) begin
         rx0 = $urandom_range(0, 50); rx1 = $urandom_range(0, 63);
         ry0 = $urandom_range(0, 30); ry1 = $urandom_range(0, 31);
         run_frame(rx0, rx1, ry0, ry1, 1'b1, org, hr, n);
         chk("rnd_orange", org, lat);
         chk("rnd_href", hr, VA * HA);
         chk("rnd_len", n, P - 1);
         @(posedge clk); #2 chk("rnd_next_vsync", VSYNC, 1);
         lat = box_area(rx0, rx1, ry0, ry1);
      end

      rx0 = $urandom_range(0, 39); rx1 = $urandom_range(20, 63);
      ry0 = $urandom_range(0, 20); ry1 = $urandom_range(10, 31);
      nxt = box_area(rx0, rx1, ry0, ry1);
      run_frame(rx0, rx1, ry0, ry1, 1'b0, org, hr, n);
      chk("drop_orange", org, lat);
      chk("drop_len", n, P - 1);
      cnt = 0;
      repeat (30) begin
         @(posedge clk); #2;
         if (VSYNC || HREF) cnt++;
      end
      chk("idle_quiet", cnt, 0);

      enable = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         n++;
         if (VSYNC) break;
      end
      chk("reenable_lat", n, 2);
      rx0 = $urandom_range(0, 39); rx1 = $urandom_range(0, 63);
      ry0 = $urandom_range(0, 23); ry1 = $urandom_range(0, 31);
      run_frame(rx0, rx1, ry0, ry1, 1'b1, org, hr, n);
      chk("reen_orange", org, nxt);
      chk("reen_len", n, P - 1);
      nxt = box_area(rx0, rx1, ry0, ry1);
      @(posedge clk); #2 chk("reen_next_vsync", VSYNC, 1);

      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         n++;
         if (HREF) break;
      end
      chk("href_found", HREF, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_href", HREF, 0);
      chk("async_vsync", VSYNC, 0);
      chk("async_rgb", {red, green, blue}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #2 chk("rst2_edge1", VSYNC, 0);
      @(posedge clk); #2 chk("rst2_edge2", VSYNC, 1);
      run_frame(rx0, rx1, ry0, ry1, 1'b1, org, hr, n);
      chk("post_rst_orange", org, nxt);
      chk("post_rst_len", n, P - 1);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
